vga_sync_monitor: RTL

- Receive-side checker for the 640x480@60 VGA sync stream, i.e. the hsync/vsync pair produced by the team's timing generator or by an external source on the same pixel clock.
- Measures line period, hsync width, frame height (in lines) and vsync width, then compares them against expected timing.
- Asserts a lock flag after consecutive good frames and pulses an error flag on any deviation.
- Used as a self-check on the board and as a scoreboard in simulation.

---
 rtl/vga_sync_monitor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for a negative-polarity hsync/vsync
// pair on the pixel clock. Measures line period, hsync width, frame height and
// vsync width, raises locked after LOCK_FRAMES consecutive good frames, and
// strobes timing_err on a bad frame or on entry into sync loss.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        video_clk,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] h_total_meas,
  output logic [10:0] h_sync_meas,
  output logic [10:0] v_total_meas,
  output logic [10:0] v_sync_meas,
  output logic        frame_pulse,
  output logic        locked,
  output logic        timing_err
);

  localparam logic [10:0] CNT_MAX   = 11'h7FF;
  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [2:0]  LOCK_N    = 3'(LOCK_FRAMES);

  // Counters stick at full scale; reaching it is what signals sync loss.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 11'd1;
  endfunction

  logic        hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
  logic        vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
  logic [10:0] hcnt_q, hcnt_d, vlines_q, vlines_d;
  logic [10:0] h_total_meas_q, h_total_meas_d, h_sync_meas_q, h_sync_meas_d;
  logic [10:0] v_total_meas_q, v_total_meas_d, v_sync_meas_q, v_sync_meas_d;
  logic        frame_pulse_q, frame_pulse_d, locked_q, locked_d;
  logic        timing_err_q, timing_err_d;
  logic [2:0]  good_cnt_q, good_cnt_d;
  logic        frame_seen_q, frame_seen_d, frame_bad_q, frame_bad_d;
  logic        line_armed_q, line_armed_d, lost_q, lost_d;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] hcnt_inc;
  logic        line_bad, h_lost, v_lost, frame_good;

  // Next-state: edge detection, measurement, frame evaluation and sync loss.
  always_comb begin
    hs_d1_d        = hsync_in;
    hs_d2_d        = hs_d1_q;
    vs_d1_d        = vsync_in;
    vs_d2_d        = vs_d1_q;
    hcnt_d         = hcnt_q;
    vlines_d       = vlines_q;
    h_total_meas_d = h_total_meas_q;
    h_sync_meas_d  = h_sync_meas_q;
    v_total_meas_d = v_total_meas_q;
    v_sync_meas_d  = v_sync_meas_q;
    frame_pulse_d  = 1'b0;
    locked_d       = locked_q;
    timing_err_d   = 1'b0;
    good_cnt_d     = good_cnt_q;
    frame_seen_d   = frame_seen_q;
    frame_bad_d    = frame_bad_q;
    line_armed_d   = line_armed_q;

    hs_fall  = hs_d2_q & ~hs_d1_q;
    hs_rise  = ~hs_d2_q & hs_d1_q;
    vs_fall  = vs_d2_q & ~vs_d1_q;
    vs_rise  = ~vs_d2_q & vs_d1_q;
    hcnt_inc = sat_inc(hcnt_q);

    // A line is judged at the fall that ends it; the first fall after reset
    // or sync loss ends no measured line and is skipped.
    line_bad = hs_fall & line_armed_q &
               ((hcnt_inc != H_TOTAL_C) | (h_sync_meas_q != H_SYNC_C));

    frame_good = ~frame_bad_q & (vlines_q == V_TOTAL_C) & (v_sync_meas_q == V_SYNC_C);

    if (hs_fall) begin
      h_total_meas_d = hcnt_inc;
      hcnt_d         = 11'd0;
      vlines_d       = sat_inc(vlines_q);
      line_armed_d   = 1'b1;
      if (line_bad) frame_bad_d = 1'b1;
    end else begin
      hcnt_d = hcnt_inc;
    end

    if (hs_rise) h_sync_meas_d = hcnt_inc;

    // vlines restarts at every vsync fall, so its value at the rise is the
    // number of hsync falls seen while vsync was low.
    if (vs_rise) v_sync_meas_d = vlines_q;

    if (vs_fall) begin
      frame_pulse_d  = 1'b1;
      // A coincident hsync fall opens the new frame: it is counted there
      // (vlines restarts at 1) and its line verdict goes to the new frame.
      v_total_meas_d = vlines_q;
      vlines_d       = hs_fall ? 11'd1 : 11'd0;
      frame_bad_d    = line_bad;
      if (!frame_seen_q) begin
        frame_seen_d = 1'b1;
      end else if (frame_good) begin
        if (good_cnt_q != LOCK_N) good_cnt_d = good_cnt_q + 3'd1;
        if (good_cnt_d == LOCK_N) locked_d = 1'b1;
      end else begin
        good_cnt_d   = 3'd0;
        locked_d     = 1'b0;
        timing_err_d = 1'b1;
      end
    end

    // Saturation that the current cycle's edge is not about to clear.
    h_lost = (hcnt_q == CNT_MAX) & ~hs_fall;
    v_lost = (vlines_q == CNT_MAX) & ~vs_fall;
    lost_d = h_lost | v_lost;
    if (h_lost) h_total_meas_d = CNT_MAX;
    if (v_lost) v_total_meas_d = CNT_MAX;
    if (lost_d) begin
      locked_d     = 1'b0;
      good_cnt_d   = 3'd0;
      frame_seen_d = 1'b0;
      line_armed_d = 1'b0;
      if (!lost_q) timing_err_d = 1'b1;
    end
  end

  // State register; sync history resets to the idle (high) level.
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d1_q        <= 1'b1;
      hs_d2_q        <= 1'b1;
      vs_d1_q        <= 1'b1;
      vs_d2_q        <= 1'b1;
      hcnt_q         <= 11'd0;
      vlines_q       <= 11'd0;
      h_total_meas_q <= 11'd0;
      h_sync_meas_q  <= 11'd0;
      v_total_meas_q <= 11'd0;
      v_sync_meas_q  <= 11'd0;
      frame_pulse_q  <= 1'b0;
      locked_q       <= 1'b0;
      timing_err_q   <= 1'b0;
      good_cnt_q     <= 3'd0;
      frame_seen_q   <= 1'b0;
      frame_bad_q    <= 1'b0;
      line_armed_q   <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      hs_d1_q        <= hs_d1_d;
      hs_d2_q        <= hs_d2_d;
      vs_d1_q        <= vs_d1_d;
      vs_d2_q        <= vs_d2_d;
      hcnt_q         <= hcnt_d;
      vlines_q       <= vlines_d;
      h_total_meas_q <= h_total_meas_d;
      h_sync_meas_q  <= h_sync_meas_d;
      v_total_meas_q <= v_total_meas_d;
      v_sync_meas_q  <= v_sync_meas_d;
      frame_pulse_q  <= frame_pulse_d;
      locked_q       <= locked_d;
      timing_err_q   <= timing_err_d;
      good_cnt_q     <= good_cnt_d;
      frame_seen_q   <= frame_seen_d;
      frame_bad_q    <= frame_bad_d;
      line_armed_q   <= line_armed_d;
      lost_q         <= lost_d;
    end
  end

  assign h_total_meas = h_total_meas_q;
  assign h_sync_meas  = h_sync_meas_q;
  assign v_total_meas = v_total_meas_q;
  assign v_sync_meas  = v_sync_meas_q;
  assign frame_pulse  = frame_pulse_q;
  assign locked       = locked_q;
  assign timing_err   = timing_err_q;

endmodule
